// File: rtl/ibwt_pkg.sv
// Shared types and helpers for the inverse BWT decoder.
// The sentinel check (IBWT_SENTINEL_CHECK_EN) lives in ibwt_top only.
package ibwt_pkg;

    typedef enum logic [2:0] {IDLE, LOAD, PREFIX, WALK, EMIT} state_e;
    typedef enum logic [1:0] {OCC_READ, OCC_LOAD, OCC_PREFIX, OCC_CLEAR} occ_mode_e;

    localparam logic [7:0] SENTINEL = 8'h24;
    localparam int         ALPHABET = 256;

    // '$' sorts below every other symbol; bytes under '$' are illegal and just shifted up.
    function automatic logic [7:0] key(input logic [7:0] b);
        if (b == SENTINEL)     key = 8'h00;
        else if (b < SENTINEL) key = b + 8'd1;
        else                   key = b;
    endfunction

endpackage

// File: rtl/ibwt_occ_table.sv
// Per-symbol occurrence table: counts during load, turned in place into the
// C[] (first-occurrence) table by a running prefix sum, then read during the walk.
module ibwt_occ_table
    import ibwt_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  occ_mode_e        mode_i,
    input  logic [7:0]       addr_i,
    output logic [CNT_W-1:0] rd_data_o
);

    logic [CNT_W-1:0] tbl   [ALPHABET];
    logic [CNT_W-1:0] sum_q;

    generate
        for (genvar gi = 0; gi < ALPHABET; gi++) begin : g_entry
            logic [CNT_W-1:0] ent_q;
            logic             hit;

            assign hit     = (addr_i == 8'(gi));
            assign tbl[gi] = ent_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)                             ent_q <= '0;
                else if (mode_i == OCC_CLEAR)           ent_q <= '0;
                else if (hit && mode_i == OCC_LOAD)     ent_q <= ent_q + CNT_W'(1);
                else if (hit && mode_i == OCC_PREFIX)   ent_q <= sum_q;
            end
        end
    endgenerate

    assign rd_data_o = tbl[addr_i];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                     sum_q <= '0;
        else if (mode_i == OCC_CLEAR)   sum_q <= '0;
        else if (mode_i == OCC_PREFIX)  sum_q <= sum_q + tbl[addr_i];
    end

endmodule

// File: rtl/ibwt_top.sv
// Inverse Burrows-Wheeler decoder: load L column, prefix-sum counts, LF walk, emit.
// Define IBWT_SENTINEL_CHECK_EN to add err_out (block did not hold exactly one '$').
module ibwt_top
    import ibwt_pkg::*;
#(
    parameter int STRING_LEN = 128
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] input_string_char,
    output logic [7:0] output_string_char,
    output logic       valid_out,
    output logic       busy
`ifdef IBWT_SENTINEL_CHECK_EN
    ,
    output logic       err_out
`endif
);

    localparam int IDX_W = $clog2(STRING_LEN);
    localparam int CNT_W = IDX_W + 1;
    localparam logic [CNT_W-1:0] LEN_C  = CNT_W'(STRING_LEN);
    localparam logic [CNT_W-1:0] LAST_C = CNT_W'(STRING_LEN - 1);
    localparam logic [IDX_W-1:0] WALK_FIRST = IDX_W'(STRING_LEN - 2);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] pos_q;
    logic [7:0]       sym_q;
    logic [IDX_W-1:0] p_q, w_q;
    logic [7:0]       out_char_q;
    logic             valid_q;

    logic [7:0]       l_mem    [STRING_LEN];
    logic [IDX_W-1:0] rank_mem [STRING_LEN];
    logic [7:0]       out_mem  [STRING_LEN];

    logic             capture;
    occ_mode_e        occ_mode;
    logic [7:0]       occ_addr;
    logic [CNT_W-1:0] occ_rd;
    logic [CNT_W-1:0] walk_sum;

    ibwt_occ_table #(.CNT_W(CNT_W)) u_occ (
        .clk       (clk),
        .rst_n     (rst),
        .mode_i    (occ_mode),
        .addr_i    (occ_addr),
        .rd_data_o (occ_rd)
    );

    // LF mapping: row of the rotation that starts with L[p].
    assign walk_sum = occ_rd + CNT_W'(rank_mem[p_q]);

    always_comb begin
        state_d  = state_q;
        capture  = 1'b0;
        occ_mode = OCC_READ;
        occ_addr = key(l_mem[p_q]);
        unique case (state_q)
            IDLE, LOAD: begin
                if (start) begin
                    capture  = 1'b1;
                    occ_mode = OCC_LOAD;
                    occ_addr = key(input_string_char);
                    if (state_q == IDLE)       state_d = LOAD;
                    else if (pos_q == LAST_C)  state_d = PREFIX;
                end
            end
            PREFIX: begin
                occ_mode = OCC_PREFIX;
                occ_addr = sym_q;
                if (sym_q == 8'hFF) state_d = WALK;
            end
            WALK: begin
                if (w_q == '0) state_d = EMIT;
            end
            EMIT: begin
                if (pos_q == LEN_C) begin
                    occ_mode = OCC_CLEAR;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            pos_q      <= '0;
            sym_q      <= '0;
            p_q        <= '0;
            w_q        <= '0;
            out_char_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= 1'b0;
            unique case (state_q)
                IDLE, LOAD: begin
                    if (capture) pos_q <= (state_d == PREFIX) ? '0 : pos_q + CNT_W'(1);
                end
                PREFIX: begin
                    sym_q <= sym_q + 8'd1;
                    p_q   <= '0;
                    w_q   <= WALK_FIRST;
                end
                WALK: begin
                    p_q <= IDX_W'(walk_sum);
                    w_q <= w_q - IDX_W'(1);
                end
                EMIT: begin
                    if (pos_q == LEN_C) begin
                        pos_q <= '0;
                    end else begin
                        valid_q    <= 1'b1;
                        out_char_q <= (pos_q == LAST_C) ? SENTINEL : out_mem[IDX_W'(pos_q)];
                        pos_q      <= pos_q + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Storage arrays carry no reset; their contents are always rewritten before use.
    always_ff @(posedge clk) begin
        if (capture) begin
            l_mem[IDX_W'(pos_q)]    <= input_string_char;
            rank_mem[IDX_W'(pos_q)] <= IDX_W'(occ_rd);
        end
        if (state_q == WALK) out_mem[w_q] <= l_mem[p_q];
    end

    assign output_string_char = out_char_q;
    assign valid_out          = valid_q;
    assign busy               = (state_q != IDLE);

`ifdef IBWT_SENTINEL_CHECK_EN
    logic [CNT_W-1:0] sent_cnt_q, sent_cnt_d;
    logic             err_q;

    assign sent_cnt_d = ((state_q == IDLE) ? '0 : sent_cnt_q)
                      + CNT_W'(input_string_char == SENTINEL);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sent_cnt_q <= '0;
            err_q      <= 1'b0;
        end else if (capture) begin
            sent_cnt_q <= sent_cnt_d;
            if (state_q == IDLE)        err_q <= 1'b0;
            else if (state_d == PREFIX) err_q <= (sent_cnt_d != CNT_W'(1));
        end
    end

    assign err_out = err_q;
`endif

endmodule

// File: tb/tb_ibwt_top.sv
// Bench for ibwt_top: three instances (lengths 7, 12, 2); expected output is the
// source string whose forward BWT (sorted rotations) is streamed in.
module tb_ibwt_top;

    localparam int NI = 3;

    typedef byte unsigned bq_t [$];

    logic       clk = 1'b0;
    logic       rst;
    logic       start_v [NI];
    logic [7:0] char_v  [NI];
    logic [7:0] out_v   [NI];
    logic       valid_v [NI];
    logic       busy_v  [NI];
`ifdef IBWT_SENTINEL_CHECK_EN
    logic       err_v   [NI];
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    generate
        for (genvar gi = 0; gi < NI; gi++) begin : g_dut
            ibwt_top #(.STRING_LEN(gi == 0 ? 7 : (gi == 1 ? 12 : 2))) u_dut (
                .clk                (clk),
                .rst                (rst),
                .start              (start_v[gi]),
                .input_string_char  (char_v[gi]),
                .output_string_char (out_v[gi]),
                .valid_out          (valid_v[gi]),
                .busy               (busy_v[gi])
`ifdef IBWT_SENTINEL_CHECK_EN
                ,
                .err_out            (err_v[gi])
`endif
            );
        end
    endgenerate

    function automatic int len_of(input int inst);
        return (inst == 0) ? 7 : ((inst == 1) ? 12 : 2);
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic bq_t to_q(input string str);
        bq_t q;
        for (int i = 0; i < str.len(); i++) q.push_back(str[i]);
        return q;
    endfunction

    // Ordering weight: '$' below everything else.
    function automatic int sym_rank(input byte unsigned c);
        return (c == 8'h24) ? 0 : int'(c) + 1;
    endfunction

    function automatic bit rot_less(input bq_t s, input int a, input int b);
        int n = s.size();
        for (int k = 0; k < n; k++) begin
            int ca = sym_rank(s[(a + k) % n]);
            int cb = sym_rank(s[(b + k) % n]);
            if (ca != cb) return ca < cb;
        end
        return 1'b0;
    endfunction

    // Forward BWT: sort all rotations, take the last column.
    function automatic bq_t bwt_of(input bq_t s);
        int  n = s.size();
        int  rot [$];
        bq_t l;
        for (int i = 0; i < n; i++) rot.push_back(i);
        for (int i = 1; i < n; i++) begin
            for (int j = i; j > 0; j--) begin
                if (rot_less(s, rot[j], rot[j-1])) begin
                    int t = rot[j];
                    rot[j]   = rot[j-1];
                    rot[j-1] = t;
                end
            end
        end
        for (int i = 0; i < n; i++) l.push_back(s[(rot[i] + n - 1) % n]);
        return l;
    endfunction

    function automatic bq_t rand_src(input int n, input int alpha);
        bq_t s;
        for (int i = 0; i < n - 1; i++) begin
            if (alpha == 0) s.push_back(8'($urandom_range(8'h25, 8'hFF)));
            else            s.push_back(8'h61 + 8'($urandom_range(0, alpha - 1)));
        end
        s.push_back(8'h24);
        return s;
    endfunction

    // Returns at the negedge after the last capture edge, with start low.
    task automatic send_bytes(input int inst, input bq_t l_in, input int stall_pos, input int stall_len);
        for (int i = 0; i < l_in.size(); i++) begin
            if (i == stall_pos) begin
                for (int s = 0; s < stall_len; s++) begin
                    start_v[inst] = 1'b0;
                    char_v[inst]  = 8'($urandom);
                    @(negedge clk);
                end
            end
            start_v[inst] = 1'b1;
            char_v[inst]  = l_in[i];
            @(negedge clk);
        end
        start_v[inst] = 1'b0;
    endtask

    task automatic run_block(input int inst, input bq_t l_in, input bq_t exp, input bit check_data,
                             input int stall_pos, input int stall_len, input bit noise);
        int n      = l_in.size();
        int c      = 0;
        int errs0  = n_errors;
        send_bytes(inst, l_in, stall_pos, stall_len);
        while (valid_v[inst] !== 1'b1 && c < 256 + n + 32) begin
            if (noise) begin
                start_v[inst] = 1'($urandom);
                char_v[inst]  = 8'($urandom);
            end
            @(negedge clk);
            c++;
        end
        check_val($sformatf("latency[%0d]", inst), c, 256 + n);
        check_val($sformatf("busy_emit[%0d]", inst), busy_v[inst], 1);
        for (int j = 0; j < n; j++) begin
            check_val($sformatf("valid[%0d][%0d]", inst, j), valid_v[inst], 1);
            if (check_data) check_val($sformatf("data[%0d][%0d]", inst, j), out_v[inst], exp[j]);
            if (noise) begin
                start_v[inst] = 1'($urandom);
                char_v[inst]  = 8'($urandom);
            end
            @(negedge clk);
        end
        start_v[inst] = 1'b0;
        check_val($sformatf("valid_end[%0d]", inst), valid_v[inst], 0);
        check_val($sformatf("busy_end[%0d]", inst), busy_v[inst], 0);
        $display("txn inst=%0d len=%0d latency=%0d stall=%0d noise=%0d new_errors=%0d",
                 inst, n, c, stall_len, noise, n_errors - errs0);
    endtask

    initial begin
        bq_t src;
        rst = 1'b0;
        for (int i = 0; i < NI; i++) begin
            start_v[i] = 1'b0;
            char_v[i]  = 8'h00;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            check_val($sformatf("rst_out[%0d]", i), out_v[i], 0);
            check_val($sformatf("rst_valid[%0d]", i), valid_v[i], 0);
            check_val($sformatf("rst_busy[%0d]", i), busy_v[i], 0);
`ifdef IBWT_SENTINEL_CHECK_EN
            check_val($sformatf("rst_err[%0d]", i), err_v[i], 0);
`endif
        end
        rst = 1'b1;
        @(negedge clk);

        run_block(0, to_q("annb$aa"), to_q("banana$"), 1'b1, -1, 0, 1'b0);
        run_block(1, to_q("ipssm$pissii"), to_q("mississippi$"), 1'b1, -1, 0, 1'b0);
        run_block(2, to_q("a$"), to_q("a$"), 1'b1, -1, 0, 1'b0);
        run_block(2, to_q("b$"), to_q("b$"), 1'b1, -1, 0, 1'b0);
        run_block(0, to_q("annb$aa"), to_q("banana$"), 1'b1, 3, 3, 1'b0);

        // Reset in the middle of the walk, then a clean block with start noise while busy.
        send_bytes(0, to_q("annb$aa"), -1, 0);
        repeat (259) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check_val("midrst_busy", busy_v[0], 0);
        check_val("midrst_valid", valid_v[0], 0);
        check_val("midrst_out", out_v[0], 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        run_block(0, to_q("annb$aa"), to_q("banana$"), 1'b1, -1, 0, 1'b1);

        for (int r = 0; r < 9; r++) begin
            int inst = r % 3;
            int n    = len_of(inst);
            src = rand_src(n, (r % 2 == 0) ? 3 : 0);
            run_block(inst, bwt_of(src), src, 1'b1, $urandom_range(0, n - 1),
                      $urandom_range(0, 3), 1'(r));
        end

`ifdef IBWT_SENTINEL_CHECK_EN
        run_block(0, to_q("annbaaa"), to_q("annbaaa"), 1'b0, -1, 0, 1'b0);
        check_val("err_set", err_v[0], 1);
        start_v[0] = 1'b1;
        char_v[0]  = 8'h61;
        @(negedge clk);
        start_v[0] = 1'b0;
        check_val("err_clear_first", err_v[0], 0);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        run_block(0, to_q("annb$aa"), to_q("banana$"), 1'b1, -1, 0, 1'b0);
        check_val("err_clear", err_v[0], 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
